mem_seq_arbiter: RTL
====================

MEM_SEQ_ARBITER -- requirements
Module: mem_seq_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, byte-address width of the shared memory port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_req  input  1  instruction-fetch word-read request, held until i_ack.
REQ-005 SHALL have port i_addr  input  ADDR_W  fetch byte address; bits [1:0] ignored.
REQ-006 SHALL have port i_ack  output  1  one-cycle pulse; i_rdata valid.
REQ-007 SHALL have port i_rdata  output  32  fetched word, little-endian.
REQ-008 SHALL have port d_req  input  1  load/store request, held with all d_* fields stable until d_ack.
REQ-009 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port d_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 SHALL have port d_addr  input  ADDR_W  data byte address.
REQ-012 SHALL have port d_wdata  input  32  store data, bytes taken from LSB upward.
REQ-013 SHALL have port d_ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port d_err  output  1  with d_ack: misaligned or illegal size, no memory access made.
REQ-015 SHALL have port d_rdata  output  32  load data, zero-extended beyond size.
REQ-016 SHALL have port mem_we  output  1  byte write enable to shared memory port.
REQ-017 SHALL have port mem_addr  output  ADDR_W  byte address to shared memory port.
REQ-018 SHALL have port mem_wd  output  8  write byte.
REQ-019 SHALL have port mem_rd  input  8  read byte, valid one cycle after its address was presented.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, DRAIN, RESP; requests are sampled only in IDLE.
REQ-021 SHALL, in IDLE with a request (cycle T0), grant one requester, latch its fields, and enter ISSUE; N = 1/2/4 bytes for byte/half/word, fetch N = 4.
REQ-022 SHALL drive mem_addr = base+k and (stores only) mem_we = 1, mem_wd = wdata[8k+7:8k] during cycle T(k+1), k = 0..N-1.
REQ-023 SHALL capture mem_rd at end of T(k+2) into rdata[8k+7:8k] for loads/fetches.
REQ-024 SHALL, for stores, go ISSUE -> RESP after T(N); ack during T(N+1) (word store: ack at T5).
REQ-025 SHALL, for reads, go ISSUE -> DRAIN (T(N+1)) -> RESP; ack during T(N+2) (word read: ack at T6).
REQ-026 SHALL return RESP -> IDLE unconditionally; requester drops or renews its request the cycle after ack.
REQ-027 SHALL treat half with addr[0]=1, word with addr[1:0]!=0, or d_size=11 as error: RESP at T1, d_ack=d_err=1, mem_we never asserted.
REQ-028 SHALL hold mem_we=0 in IDLE, DRAIN, RESP; mem_addr holds its last value.
REQ-029 SHALL hold i_rdata/d_rdata stable from ack until the next grant to that requester.
REQ-030 SHALL, with only one request present in IDLE, grant it regardless of arbitration policy.

Reset
REQ-031 SHALL, with rst_n low at a rising edge, enter IDLE with all outputs 0, rdata registers 0, last-grant = fetch.
REQ-032 SHALL abort an in-flight transaction on reset: no further mem_we, no ack issued.

Configuration
REQ-033 SHALL, with ARB_ROUND_ROBIN_EN defined, on simultaneous requests grant the requester not granted last (data first after reset).
REQ-034 SHALL, without ARB_ROUND_ROBIN_EN, on simultaneous requests always grant data.

Verification
REQ-035 SHALL cover: fetch i_addr=0x00100, memory bytes 11,22,33,44 -> i_ack at T6, i_rdata=0x44332211, mem_we never 1.
REQ-036 SHALL cover: store word 0xDEADBEEF to 0x00200 -> mem_we T1..T4 at 0x200..0x203 with EF,BE,AD,DE; d_ack T5.
REQ-037 SHALL cover: load half at 0x00201 -> d_ack=d_err=1 at T1, no memory cycle; load byte at 0x00203 after REQ-036 -> d_rdata=0x000000DE at T3.
REQ-038 SHALL cover: i_req and d_req held continuously -> grants alternate data, fetch, data with macro; data only without.
REQ-039 SHALL cover: rst_n low at T2 of a word store -> only byte 0 written, no d_ack, all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_seq_arbiter.sv
// Byte-serial arbiter: instruction fetch and load/store share one 8-bit memory port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention (else data always wins).
module mem_seq_arbiter #(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    input  logic [7:0]        mem_rd
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t      state;
    logic        is_fetch;
    logic        is_store;
    logic        last_fetch;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic [23:0] wbuf;
    logic        grant_d;
    logic        d_bad;
    logic [1:0]  d_last;
    logic        cap_en;
    logic [1:0]  cap_pos;
    logic [4:0]  cap_bit;
    logic        unused_ok;

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_d = d_req && (!i_req || last_fetch);
`else
    assign grant_d = d_req;
`endif

    assign unused_ok = ^{i_addr[1:0], last_fetch};

    assign d_bad = (d_size == 2'b11)
                 | ((d_size == 2'b01) & d_addr[0])
                 | ((d_size == 2'b10) & (|d_addr[1:0]));

    always_comb begin
        d_last = 2'd0;
        unique case (1'b1)
            (d_size == 2'b01): d_last = 2'd1;
            (d_size == 2'b10): d_last = 2'd3;
            default:           d_last = 2'd0;
        endcase
    end

    // Read byte k returns one cycle after its address, so capture lags issue by one.
    assign cap_en  = (state == DRAIN)
                   || ((state == ISSUE) && !is_store && (idx != 2'd0));
    assign cap_pos = (state == DRAIN) ? idx : idx - 2'd1;
    assign cap_bit = {cap_pos, 3'b000};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_fetch   <= 1'b0;
            is_store   <= 1'b0;
            last_fetch <= 1'b1;
            idx        <= 2'd0;
            last_idx   <= 2'd0;
            wbuf       <= '0;
            i_ack      <= 1'b0;
            i_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            if (cap_en) begin
                if (is_fetch) i_rdata[cap_bit +: 8] <= mem_rd;
                else          d_rdata[cap_bit +: 8] <= mem_rd;
            end
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        last_fetch <= 1'b0;
                        is_fetch   <= 1'b0;
                        if (d_bad) begin
                            state <= RESP;
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            is_store <= d_we;
                            idx      <= 2'd0;
                            last_idx <= d_last;
                            mem_addr <= d_addr;
                            mem_we   <= d_we;
                            mem_wd   <= d_wdata[7:0];
                            wbuf     <= d_wdata[31:8];
                            if (!d_we) d_rdata <= '0;
                        end
                    end else if (i_req) begin
                        last_fetch <= 1'b1;
                        is_fetch   <= 1'b1;
                        is_store   <= 1'b0;
                        state      <= ISSUE;
                        idx        <= 2'd0;
                        last_idx   <= 2'd3;
                        mem_addr   <= {i_addr[ADDR_W-1:2], 2'b00};
                        i_rdata    <= '0;
                    end
                end
                ISSUE: begin
                    if (idx == last_idx) begin
                        mem_we <= 1'b0;
                        if (is_store) begin
                            state <= RESP;
                            d_ack <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idx      <= idx + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_wd   <= wbuf[7:0];
                        wbuf     <= wbuf >> 8;
                    end
                end
                DRAIN: begin
                    state <= RESP;
                    if (is_fetch) i_ack <= 1'b1;
                    else          d_ack <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
